mux_pipe: RTL and testbench
===========================

MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 SHALL have parameter N, default 8: number of input words; power of two, N >= 2.
REQ-002 SHALL have parameter W, default 2: bits per word.
REQ-003 SHALL use the derived constant L = log2(N) for select width and pipeline depth.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port a, input, N*W bits: packed words; word i = a[i*W +: W].
REQ-007 SHALL have port s, input, L bits: word select, sampled with a.
REQ-008 SHALL have port in_valid, input, 1 bit: a/s hold a transaction.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a transaction this cycle.
REQ-010 SHALL have port y, output, W bits: selected word.
REQ-011 SHALL have port out_valid, output, 1 bit: y holds a transaction.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts y this cycle.

Function
REQ-013 SHALL implement a binary mux tree of L registered stages; stage k (k=0..L-1) holds N/2^(k+1) words, the remaining select bits s[L-1:k+1], and one valid flag.
REQ-014 SHALL have stage k reduce word pairs (2j, 2j+1) to word j, using select bit s[k] (LSB first): 0 picks the even word, 1 picks the odd word.
REQ-015 SHALL produce y equal to word s of the accepted a, i.e. a[s*W +: W], for every transaction.
REQ-016 SHALL transfer a transaction on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-017 SHALL have latency exactly L cycles from input transfer to out_valid when out_ready stays high.
REQ-018 SHALL sustain throughput of one transaction per cycle when out_ready stays high.
REQ-019 SHALL compute per-stage ready as ready_k = !valid_k || ready_(k+1), with the last stage using out_ready; in_ready = ready_0.
REQ-020 SHALL let a stage whose ready is high load its predecessor's result and valid; a stage whose ready is low holds data and valid unchanged.
REQ-021 SHALL let bubbles collapse: an empty stage accepts even while downstream stalls.
REQ-022 SHALL keep y and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, when the pipe is full and out_ready is high, accept a new input in the same cycle that output transfers; no loss, no duplication.
REQ-024 SHALL let y hold its last transferred value when out_valid is low; data registers load only on a valid advance.
REQ-025 SHALL ignore a, s and in_valid when in_ready is low; no state change results.
REQ-026 SHALL, for N=2 (L=1), use one stage with behaviour otherwise identical.
REQ-027 SHALL be built from the existing 2:1 mux cell per bit per pair; no behavioural case or index selection.

Reset
REQ-028 SHALL, while rst is high, clear all stage valid flags, data registers and select registers to 0 asynchronously; out_valid=0, y=0, in_ready=1.
REQ-029 SHALL discard all in-flight transactions when rst asserts mid-operation; none appear after release.
REQ-030 SHALL accept a transaction on the first rising clk edge after rst deasserts, given in_valid=1.

Verification
REQ-031 SHALL cover single transfer: N=8, W=2, a=16'hE4B1, s=3, out_ready=1 -> out_valid high 3 cycles later, y=2'b10.
REQ-032 SHALL cover streaming: s=0..7 on consecutive cycles with a fixed, out_ready=1 -> y = words 0..7 on 8 consecutive cycles starting at cycle 3, no gaps.
REQ-033 SHALL cover backpressure: hold out_ready=0 while driving 4 transactions -> exactly 3 accepted, in_ready low thereafter, y frozen; raise out_ready -> all 3 then the 4th emerge in order.
REQ-034 SHALL cover bubble collapse: one transaction, 2-cycle gap, one transaction, out_ready=0 -> both accepted (in_ready stays high), delivered in order once out_ready=1.
REQ-035 SHALL cover reset mid-stream: assert rst with 3 transactions in flight -> out_valid=0 and y=0 immediately; nothing emitted after release.
REQ-036 SHALL cover parameter sweep: N in {2,4,16}, W in {1,8}, random a/s/out_ready for 10k cycles -> every output equals a scoreboard model in order, latency L when unstalled.

Source files
------------

// File: rtl/mux_pipe_if.sv
// mux_pipe_if: transaction bundle for the pipelined word multiplexer.
// Carries the packed input words, the word select, the ready/valid
// handshake on both sides and the selected output word.
interface mux_pipe_if #(
    parameter int N = 8,
    parameter int W = 2
);
    localparam int L = $clog2(N);

    logic [N*W-1:0] a;
    logic [L-1:0]   s;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;

    // Producer/consumer side: drives the words and select, consumes y.
    modport master (
        output a,
        output s,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  y,
        input  out_valid
    );

    // Multiplexer side: accepts the words and select, presents y.
    modport slave (
        input  a,
        input  s,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output y,
        output out_valid
    );
endinterface

// File: rtl/mux_pipe.sv
// mux_pipe: N:1 word multiplexer built as a binary tree of L = log2(N)
// registered stages with a ready/valid handshake between every stage.
// Stage k halves the word count using select bit s[k] (LSB first) and
// carries the still-unused select bits s[L-1:k+1] along with its data,
// so a new transaction can enter every cycle. Per-stage ready is
// !valid || downstream ready, which lets empty stages (bubbles) fill up
// even while the consumer stalls.
module mux_pipe #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic      clk,
    input  logic      rst,
    mux_pipe_if.slave bus
);
    localparam int L = $clog2(N);

    for (genvar k = 0; k < L; k++) begin : stage
        // Output words held by this stage and select bits still to be used.
        localparam int WO = (N >> (k + 1)) * W;
        localparam int SR = L - k - 1;

        logic [2*WO-1:0] d_in;
        logic            sel_bit;
        logic            v_in;
        logic            ready;
        logic            load;
        logic [WO-1:0]   mux_out;
        logic [WO-1:0]   data_q;
        logic            valid_q;

        // Stage 0 reads the bus directly; later stages read their predecessor.
        if (k == 0) begin : g_src
            assign d_in    = bus.a;
            assign sel_bit = bus.s[0];
            assign v_in    = bus.in_valid;
        end else begin : g_src
            assign d_in    = stage[k-1].data_q;
            assign sel_bit = stage[k-1].g_sel.sel_q[0];
            assign v_in    = stage[k-1].valid_q;
        end

        // The last stage is released by the consumer, others by the next stage.
        if (k == L - 1) begin : g_rdy
            assign ready = !valid_q || bus.out_ready;
        end else begin : g_rdy
            assign ready = !valid_q || stage[k+1].ready;
        end

        assign load = ready && v_in;

        // One 2:1 cell per bit per word pair: even word on d0, odd word on d1.
        for (genvar j = 0; j < WO / W; j++) begin : g_pair
            for (genvar b = 0; b < W; b++) begin : g_bit
                mux2_cell u_mux (
                    .d0  (d_in[(2*j)*W + b]),
                    .d1  (d_in[(2*j+1)*W + b]),
                    .sel (sel_bit),
                    .q   (mux_out[j*W + b])
                );
            end
        end

        // Valid flag follows the predecessor whenever this stage may advance.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (ready) begin
                valid_q <= v_in;
            end
        end

        // Data only moves on a valid advance, so it keeps its last value when idle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (load) begin
                data_q <= mux_out;
            end
        end

        // Remaining select bits travel with the data; the last stage needs none.
        if (SR > 0) begin : g_sel
            logic [SR-1:0] sel_in;
            logic [SR-1:0] sel_q;

            if (k == 0) begin : g_ssrc
                assign sel_in = bus.s[L-1:1];
            end else begin : g_ssrc
                assign sel_in = stage[k-1].g_sel.sel_q[SR:1];
            end

            // Select bits load together with the data they steer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sel_q <= '0;
                end else if (load) begin
                    sel_q <= sel_in;
                end
            end
        end
    end

    assign bus.y         = stage[L-1].data_q;
    assign bus.out_valid = stage[L-1].valid_q;
    assign bus.in_ready  = stage[0].ready;
endmodule

// mux2_cell: single-bit 2:1 multiplexer; sel=0 passes d0, sel=1 passes d1.
module mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic q
);
    assign q = sel ? d1 : d0;
endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: self-checking bench for mux_pipe. The main instance is
// N=8, W=2; three more instances (N/W = 2/8, 4/1, 16/8) run random
// traffic with their own scoreboards in parallel.
module tb_mux_pipe;
    localparam int N = 8;
    localparam int W = 2;
    localparam int L = 3;
    localparam int SWEEP_CYCLES = 10000;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic rst_sw = 1'b1;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   acc_cnt    = 0;
    int   sweep_done = 0;
    bit   strict_lat = 1'b0;
    logic [W-1:0] cur_exp = '0;

    typedef struct {
        logic [N*W-1:0] a;
        logic [L-1:0]   s;
        logic [W-1:0]   y;
    } vec_t;

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
        bit           strict;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[9];
    logic [L-1:0] bp_s[4];
    logic [W-1:0] bp_y[4];

    mux_pipe_if #(.N(N), .W(W)) bus ();

    mux_pipe #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic logic [W-1:0] model_word(input logic [N*W-1:0] a, input int s);
        return W'(a >> (s * W));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [N*W-1:0] a, input logic [L-1:0] s,
                                  input logic v, input logic [W-1:0] e);
        bus.a        = a;
        bus.s        = s;
        bus.in_valid = v;
        cur_exp      = e;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) next_cycle();
        check(name, exp_q.size(), 0);
    endtask

    // Main scoreboard: push on input transfer, pop and compare on output transfer.
    logic         stall_prev = 1'b0;
    logic [W-1:0] y_prev     = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_y", bus.y, y_prev);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back('{y: cur_exp, cyc: cyc, strict: strict_lat});
                acc_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("output_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("y_value", bus.y, e.y);
                    if (e.strict) check("latency_exact", cyc - e.cyc, L);
                    else          check("latency_min", (cyc - e.cyc) >= L, 1);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            y_prev     = bus.y;
        end
    end

    // Directed and table-driven sequences on the N=8, W=2 instance.
    initial begin
        int base;
        int n;

        tbl[0] = '{a: 16'hE4B1, s: 3'd3, y: 2'b10};
        tbl[1] = '{a: 16'hE4B1, s: 3'd0, y: 2'b01};
        tbl[2] = '{a: 16'hE4B1, s: 3'd7, y: 2'b11};
        tbl[3] = '{a: 16'hE4B1, s: 3'd2, y: 2'b11};
        tbl[4] = '{a: 16'h0000, s: 3'd5, y: 2'b00};
        tbl[5] = '{a: 16'hFFFF, s: 3'd6, y: 2'b11};
        tbl[6] = '{a: 16'h8000, s: 3'd7, y: 2'b10};
        tbl[7] = '{a: 16'h1234, s: 3'd4, y: 2'b10};
        tbl[8] = '{a: 16'h1234, s: 3'd1, y: 2'b01};

        bp_s[0] = 3'd1; bp_y[0] = 2'b00;
        bp_s[1] = 3'd2; bp_y[1] = 2'b11;
        bp_s[2] = 3'd5; bp_y[2] = 2'b01;
        bp_s[3] = 3'd6; bp_y[3] = 2'b10;

        bus.out_ready = 1'b1;
        apply_stimulus('0, '0, 1'b0, '0);
        next_cycle();
        next_cycle();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_y", bus.y, 0);
        check("reset_in_ready", bus.in_ready, 1);
        rst_sw = 1'b0;

        // Table vectors streamed back to back; the first is accepted on the first edge after release.
        $display("[TB] table vectors");
        strict_lat = 1'b1;
        base = acc_cnt;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(tbl[i].a, tbl[i].s, 1'b1, tbl[i].y);
            next_cycle();
        end
        apply_stimulus('0, '0, 1'b0, '0);
        check("table_accepted", acc_cnt - base, 9);
        drain("drain_table");

        // Streaming s = 0..7 with a fixed word set.
        $display("[TB] streaming");
        base = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'h1234, L'(i), 1'b1, model_word(16'h1234, i));
            next_cycle();
        end
        apply_stimulus('0, '0, 1'b0, '0);
        check("stream_accepted", acc_cnt - base, 8);
        drain("drain_stream");

        // Backpressure: only three fit while the consumer stalls.
        $display("[TB] backpressure");
        strict_lat    = 1'b0;
        bus.out_ready = 1'b0;
        base = acc_cnt;
        apply_stimulus(16'hE4B1, bp_s[0], 1'b1, bp_y[0]);
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            n = acc_cnt - base;
            if (n < 4) apply_stimulus(16'hE4B1, bp_s[n], 1'b1, bp_y[n]);
        end
        check("bp_accepted", acc_cnt - base, 3);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_head_y", bus.y, bp_y[0]);
        repeat (3) next_cycle();
        check("bp_y_frozen", bus.y, bp_y[0]);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (acc_cnt - base) < 4; c++) begin
            next_cycle();
            n = acc_cnt - base;
            if (n < 4) apply_stimulus(16'hE4B1, bp_s[n], 1'b1, bp_y[n]);
        end
        apply_stimulus('0, '0, 1'b0, '0);
        check("bp_all_accepted", acc_cnt - base, 4);
        drain("drain_bp");

        // Bubble collapse: the second transaction still enters while the consumer stalls.
        $display("[TB] bubble collapse");
        bus.out_ready = 1'b0;
        base = acc_cnt;
        apply_stimulus(16'h1234, 3'd4, 1'b1, 2'b10);
        next_cycle();
        apply_stimulus('0, '0, 1'b0, '0);
        check("bub_first_accepted", acc_cnt - base, 1);
        next_cycle();
        check("bub_gap_in_ready", bus.in_ready, 1);
        next_cycle();
        apply_stimulus(16'h1234, 3'd1, 1'b1, 2'b01);
        check("bub_in_ready", bus.in_ready, 1);
        next_cycle();
        apply_stimulus('0, '0, 1'b0, '0);
        check("bub_second_accepted", acc_cnt - base, 2);
        repeat (3) next_cycle();
        check("bub_out_valid", bus.out_valid, 1);
        check("bub_head_y", bus.y, 2'b10);
        bus.out_ready = 1'b1;
        drain("drain_bubble");

        // Reset with three transactions in flight.
        $display("[TB] reset mid-stream");
        strict_lat = 1'b1;
        base = acc_cnt;
        apply_stimulus(16'hE4B1, 3'd0, 1'b1, 2'b01);
        next_cycle();
        apply_stimulus(16'hE4B1, 3'd3, 1'b1, 2'b10);
        next_cycle();
        apply_stimulus(16'hE4B1, 3'd7, 1'b1, 2'b11);
        next_cycle();
        apply_stimulus('0, '0, 1'b0, '0);
        check("rm_accepted", acc_cnt - base, 3);
        rst = 1'b1;
        #1;
        check("rm_out_valid", bus.out_valid, 0);
        check("rm_y", bus.y, 0);
        check("rm_in_ready", bus.in_ready, 1);
        exp_q.delete();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            check("rm_quiet", bus.out_valid, 0);
        end

        for (int c = 0; c < 30000 && sweep_done < 3; c++) next_cycle();
        check("sweep_finished", sweep_done, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Parameter sweep: random words, selects, valid and consumer stalls.
    for (genvar g = 0; g < 3; g++) begin : sweep
        localparam int SN = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
        localparam int SW = (g == 1) ? 1 : 8;
        localparam int SL = $clog2(SN);

        mux_pipe_if #(.N(SN), .W(SW)) sbus ();

        mux_pipe #(.N(SN), .W(SW)) dut (
            .clk (clk),
            .rst (rst_sw),
            .bus (sbus.slave)
        );

        logic [SW-1:0] exp_y_q[$];
        int            exp_c_q[$];
        logic [SW-1:0] s_exp      = '0;
        int            stall_from = 32'h3fff_ffff;

        always @(negedge clk) begin : smon
            logic [SW-1:0] ey;
            int            ec;
            if (!rst_sw) begin
                if (sbus.in_valid && sbus.in_ready) begin
                    exp_y_q.push_back(s_exp);
                    exp_c_q.push_back(cyc);
                end
                if (sbus.out_valid && sbus.out_ready) begin
                    check($sformatf("sweep%0d_has_expected", g), exp_y_q.size() > 0, 1);
                    if (exp_y_q.size() > 0) begin
                        ey = exp_y_q.pop_front();
                        ec = exp_c_q.pop_front();
                        check($sformatf("sweep%0d_y", g), sbus.y, ey);
                        if (cyc < stall_from) check($sformatf("sweep%0d_latency_exact", g), cyc - ec, SL);
                        else                  check($sformatf("sweep%0d_latency_min", g), (cyc - ec) >= SL, 1);
                    end
                end
            end
        end

        initial begin
            sbus.in_valid  = 1'b0;
            sbus.a         = '0;
            sbus.s         = '0;
            sbus.out_ready = 1'b1;
            wait (rst_sw == 1'b0);
            for (int i = 0; i < SWEEP_CYCLES; i++) begin
                @(posedge clk);
                #1;
                if (i == 300) stall_from = cyc;
                sbus.out_ready = (i < 300) ? 1'b1 : 1'($urandom_range(0, 9) < 7);
                sbus.in_valid  = 1'($urandom_range(0, 3) != 0);
                for (int b = 0; b < SN * SW; b++) sbus.a[b] = 1'($urandom_range(0, 1));
                sbus.s = SL'($urandom_range(0, SN - 1));
                s_exp  = SW'(sbus.a >> (int'(sbus.s) * SW));
            end
            @(posedge clk);
            #1;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b1;
            for (int c = 0; c < 4 * SL + 10 && exp_y_q.size() != 0; c++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("sweep%0d_drain", g), exp_y_q.size(), 0);
            sweep_done++;
        end
    end
endmodule
